// File: rtl/adapter_8_32_pkg.sv
// Shared types and constants for the SiTCP 8<->32 AXI4-Lite adapters.
package adapter_8_32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M_AR = 2'd1,
        M_R  = 2'd2,
        S_R  = 2'd3
    } state_t;

    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [1:0]  RESP_SLVERR    = 2'b10;
    localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/adapter_8_32_r.sv
// Byte-side AXI4-Lite read adapter: fetches the containing 32-bit word once and serves it from a buffer.
// Define ADAPTER_8_32_R_CACHE_EN to let lanes 1-3 of the last fetched word hit the buffer.
module adapter_8_32_r
    import adapter_8_32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] m_axi_araddr,
    output logic [2:0]  m_axi_arprot,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready
);

    // Handshake rule on both sides: a beat transfers on the rising edge where
    // valid and ready are both high; valid, address and data hold until then.

    state_t      state;
    state_t      state_next;
    logic        arready_q;
    logic        ar_hs;
    logic        hit;
    logic [31:0] addr_q;
    logic [31:0] buf_data;
    logic [1:0]  buf_resp;

    logic unused_ok;
    assign unused_ok = &{1'b0, s_axi_arprot};

    assign ar_hs = s_axi_arvalid && arready_q;

`ifdef ADAPTER_8_32_R_CACHE_EN
    logic        buf_valid;
    logic [29:0] buf_tag;

    // Lane 0 never hits: it is the point where a multi-byte register is sampled.
    assign hit = buf_valid && (s_axi_araddr[31:2] == buf_tag) && (s_axi_araddr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
        end else if (state == M_R && m_axi_rvalid) begin
            buf_valid <= 1'b1;
            buf_tag   <= addr_q[31:2];
        end else if (state == S_R && s_axi_rready && buf_resp != RESP_OKAY) begin
            buf_valid <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_q <= 1'b0;
            addr_q    <= '0;
            buf_data  <= '0;
            buf_resp  <= RESP_OKAY;
        end else begin
            arready_q <= (state == IDLE) && s_axi_arvalid && !arready_q;
            if (ar_hs) begin
                addr_q <= s_axi_araddr & WORD_ADDR_MASK;
            end
            if (state == M_R && m_axi_rvalid) begin
                buf_data <= m_axi_rdata;
                buf_resp <= m_axi_rresp;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ar_hs)         state_next = hit ? S_R : M_AR;
            M_AR:    if (m_axi_arready) state_next = M_R;
            M_R:     if (m_axi_rvalid)  state_next = S_R;
            S_R:     if (s_axi_rready)  state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        s_axi_arready = arready_q;
        s_axi_rvalid  = (state == S_R);
        s_axi_rdata   = buf_data;
        s_axi_rresp   = buf_resp;
        m_axi_arvalid = (state == M_AR);
        m_axi_araddr  = addr_q;
        m_axi_arprot  = 3'b000;
        m_axi_rready  = (state == M_R);
    end

endmodule

// File: tb/tb_adapter_8_32_r.sv
// Self-checking bench for adapter_8_32_r; honours ADAPTER_8_32_R_CACHE_EN in its reference model.
module tb_adapter_8_32_r;
    import adapter_8_32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_axi_araddr = '0;
    logic [2:0]  s_axi_arprot = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    int checks = 0;
    int failures = 0;

    // Reference model: the last fetched word and whether it may be reused.
    logic        mdl_valid = 1'b0;
    logic [29:0] mdl_tag = '0;
    logic [31:0] mdl_data = '0;
    logic [1:0]  mdl_resp = '0;

    adapter_8_32_r dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    function automatic logic mdl_hit(input logic [31:0] a);
`ifdef ADAPTER_8_32_R_CACHE_EN
        return mdl_valid && (a[31:2] == mdl_tag) && (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [77:0] all_outputs();
        return {s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rresp,
                m_axi_arvalid, m_axi_araddr, m_axi_rready, m_axi_arprot};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_valid = 1'b0;
    endtask

    // One full slave read, with the bench also acting as the 32-bit master.
    task automatic do_read(input logic [31:0] addr, input logic [31:0] mdata,
                           input logic [1:0] mresp, input int ar_wait,
                           input int rr_wait, input string name);
        logic        hit;
        logic [31:0] exp_word;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        int ar_cyc, rv_cyc, mrd, n_ar, aw, rw, exp_lat;
        bit drop_ar, rel_r, done, prev_mv;
        hit = mdl_hit(addr);
        exp_word = addr & WORD_ADDR_MASK;
        exp_data = hit ? mdl_data : mdata;
        exp_resp = hit ? mdl_resp : mresp;
        exp_lat = hit ? 1 : 3 + ar_wait;
        ar_cyc = -1; rv_cyc = -1; mrd = 0; n_ar = 0; aw = ar_wait; rw = rr_wait;
        drop_ar = 0; rel_r = 0; done = 0; prev_mv = 0;
        @(negedge clk);
        s_axi_araddr = addr;
        s_axi_arvalid = 1'b1;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk);
            if (drop_ar) begin
                s_axi_arvalid = 1'b0;
                drop_ar = 0;
            end
            if (s_axi_arready) begin
                n_ar++;
                if (ar_cyc < 0 && s_axi_arvalid) begin
                    ar_cyc = cyc;
                    drop_ar = 1;
                end
            end
            if (m_axi_arvalid && !prev_mv) mrd++;
            prev_mv = m_axi_arvalid;
            if (m_axi_arvalid) begin
                checks++;
                if (m_axi_araddr !== exp_word) begin
                    failures++;
                    $display("FAIL %s m_araddr got=%h exp=%h", name, m_axi_araddr, exp_word);
                end
                if (aw > 0) begin
                    m_axi_arready = 1'b0;
                    aw--;
                end else begin
                    m_axi_arready = 1'b1;
                end
            end else begin
                m_axi_arready = 1'b0;
            end
            if (m_axi_rready) begin
                m_axi_rvalid = 1'b1;
                m_axi_rdata = mdata;
                m_axi_rresp = mresp;
            end else begin
                m_axi_rvalid = 1'b0;
                m_axi_rdata = $urandom;
                m_axi_rresp = 2'($urandom_range(0, 3));
            end
            if (rel_r) begin
                s_axi_rready = 1'b0;
                done = 1;
                checks++;
                if (s_axi_rvalid !== 1'b0) begin
                    failures++;
                    $display("FAIL %s rvalid_after_hs got=%b exp=0", name, s_axi_rvalid);
                end
            end else if (s_axi_rvalid) begin
                if (rv_cyc < 0) begin
                    rv_cyc = cyc;
                    checks++;
                    if (rv_cyc - ar_cyc != exp_lat) begin
                        failures++;
                        $display("FAIL %s latency got=%0d exp=%0d", name, rv_cyc - ar_cyc, exp_lat);
                    end
                end
                checks++;
                if (s_axi_rdata !== exp_data) begin
                    failures++;
                    $display("FAIL %s rdata got=%h exp=%h", name, s_axi_rdata, exp_data);
                end
                checks++;
                if (s_axi_rresp !== exp_resp) begin
                    failures++;
                    $display("FAIL %s rresp got=%b exp=%b", name, s_axi_rresp, exp_resp);
                end
                if (rw > 0) begin
                    rw--;
                end else begin
                    s_axi_rready = 1'b1;
                    rel_r = 1;
                end
            end
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rvalid = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL %s timeout got=incomplete exp=complete", name);
        end
        checks++;
        if (mrd != (hit ? 0 : 1)) begin
            failures++;
            $display("FAIL %s master_reads got=%0d exp=%0d", name, mrd, hit ? 0 : 1);
        end
        checks++;
        if (n_ar != 1) begin
            failures++;
            $display("FAIL %s arready_pulses got=%0d exp=1", name, n_ar);
        end
        if (!hit) begin
            mdl_valid = (mresp == RESP_OKAY);
            mdl_tag = addr[31:2];
            mdl_data = mdata;
            mdl_resp = mresp;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL reset outputs got=%h exp=0", all_outputs());
        end
        rst = 1'b0;
        mdl_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({s_axi_rvalid, m_axi_arvalid, s_axi_arready} !== 3'b000) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=000", {s_axi_rvalid, m_axi_arvalid, s_axi_arready});
        end
    endtask

    task automatic test_same_word();
        for (int i = 0; i < 4; i++) begin
            do_read(32'h10 + 32'(i), 32'hDEADBEEF, RESP_OKAY, 0, 0, "same_word");
        end
    endtask

    task automatic test_cold();
        apply_reset();
        do_read(32'h11, 32'hCAFE0011, RESP_OKAY, 0, 0, "cold");
    endtask

    task automatic test_refetch_lane0();
        do_read(32'h10, 32'h11111111, RESP_OKAY, 0, 0, "lane0_a");
        do_read(32'h10, 32'h22222222, RESP_OKAY, 0, 0, "lane0_b");
    endtask

    task automatic test_error_resp();
        do_read(32'h20, 32'hBAD0BAD0, RESP_SLVERR, 0, 0, "err");
        do_read(32'h21, 32'h00002121, RESP_OKAY, 0, 0, "after_err");
    endtask

    task automatic test_stall();
        do_read(32'h50, $urandom, RESP_OKAY, 5, 3, "stall");
    endtask

    task automatic test_abort_arvalid();
        @(negedge clk);
        s_axi_araddr = 32'h44;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_arready !== 1'b1) begin
            failures++;
            $display("FAIL abort arready got=%b exp=1", s_axi_arready);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({s_axi_arready, m_axi_arvalid, s_axi_rvalid} !== 3'b000) begin
                failures++;
                $display("FAIL abort idle got=%b exp=000", {s_axi_arready, m_axi_arvalid, s_axi_rvalid});
            end
        end
        do_read(32'h44, 32'h4444AAAA, RESP_OKAY, 0, 0, "after_abort");
    endtask

    task automatic test_reset_mid();
        bit seen;
        do_read(32'h30, 32'h30303030, RESP_OKAY, 0, 0, "prime");
        do_read(32'h31, 32'h0, RESP_OKAY, 0, 0, "prime_hit");
        @(negedge clk);
        s_axi_araddr = 32'h30;
        s_axi_arvalid = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = s_axi_arready;
        end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        checks++;
        if (m_axi_rready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid in_m_r got=%b exp=1", m_axi_rready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (all_outputs() !== '0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%h exp=0", all_outputs());
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mdl_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({s_axi_rvalid, m_axi_arvalid} !== 2'b00) begin
                failures++;
                $display("FAIL reset_mid late got=%b exp=00", {s_axi_rvalid, m_axi_arvalid});
            end
        end
        do_read(32'h31, 32'h31313131, RESP_OKAY, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  r;
        for (int i = 0; i < 40; i++) begin
            a = 32'h100 + 32'(4 * $urandom_range(0, 2)) + 32'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
            do_read(a, $urandom, r, $urandom_range(0, 2), $urandom_range(0, 2), "random");
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_same_word();
        test_refetch_lane0();
        test_error_resp();
        test_stall();
        test_abort_arvalid();
        test_cold();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
